// File: rtl/qcom_issuer_if.sv
// Bundle of command, peripheral and status signals around qcom_issuer.
// The slave view belongs to the issuer; the master view drives it.
interface qcom_issuer_if #(
    parameter int FIFO_AW = 3
);
    logic               cmd_vld_i;
    logic [4:0]         cmd_op_i;
    logic [31:0]        cmd_dt_i;
    logic               cmd_rdy_o;
    logic               qcom_en_o;
    logic [4:0]         qcom_op_o;
    logic [31:0]        qcom_dt1_o;
    logic               qcom_rdy_i;
    logic               qcom_vld_i;
    logic [31:0]        qcom_dt1_i;
    logic [31:0]        qcom_dt2_i;
    logic               qcom_flag_i;
    logic               rsp_vld_o;
    logic [31:0]        rsp_dt1_o;
    logic [31:0]        rsp_dt2_o;
    logic               rsp_flag_o;
    logic               busy_o;
    logic [FIFO_AW:0]   pend_o;
    logic [1:0]         err_o;
    logic               err_clr_i;

    modport slave (
        input  cmd_vld_i, cmd_op_i, cmd_dt_i, qcom_rdy_i, qcom_vld_i,
               qcom_dt1_i, qcom_dt2_i, qcom_flag_i, err_clr_i,
        output cmd_rdy_o, qcom_en_o, qcom_op_o, qcom_dt1_o, rsp_vld_o,
               rsp_dt1_o, rsp_dt2_o, rsp_flag_o, busy_o, pend_o, err_o
    );

    modport master (
        output cmd_vld_i, cmd_op_i, cmd_dt_i, qcom_rdy_i, qcom_vld_i,
               qcom_dt1_i, qcom_dt2_i, qcom_flag_i, err_clr_i,
        input  cmd_rdy_o, qcom_en_o, qcom_op_o, qcom_dt1_o, rsp_vld_o,
               rsp_dt1_o, rsp_dt2_o, rsp_flag_o, busy_o, pend_o, err_o
    );
endinterface

// File: rtl/qcom_issuer.sv
// Queues commands in a small FIFO and issues them one at a time to the QCOM
// peripheral, supervising its rdy handshake with ack/done timeouts.
module qcom_issuer #(
    parameter int FIFO_AW = 3,
    parameter int ACK_TO  = 15,
    parameter int DONE_TO = 1023
) (
    input  logic          c_clk_i,
    input  logic          c_rst_i,
    qcom_issuer_if.slave  bus
);
    localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [9:0]       ACK_LIM  = 10'(ACK_TO);
    localparam logic [9:0]       DONE_LIM = 10'(DONE_TO);
    localparam logic [9:0]       TMR_MAX  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK, ST_DONE} state_e;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] dt;
    } cmd_t;

    cmd_t               mem_q [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    state_e             state_q, state_d;
    logic [9:0]         tmr_q, tmr_d, tmr_inc;
    logic               en_q, en_d, busy_q, busy_d;
    logic [4:0]         op_q, op_d;
    logic [31:0]        dt_q, dt_d;
    logic [1:0]         err_q, err_d, err_set;
    logic               rsp_vld_q, rsp_vld_d, rsp_flag_q, rsp_flag_d;
    logic [31:0]        rsp_dt1_q, rsp_dt1_d, rsp_dt2_q, rsp_dt2_d;
    logic               cmd_rdy, push, pop;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        tmr_d   = tmr_q;
        op_d    = op_q;
        dt_d    = dt_q;
        err_set = '0;

        cmd_rdy  = (cnt_q < DEPTH);
        push     = bus.cmd_vld_i && cmd_rdy;
        pop      = (state_q == ST_IDLE) && (cnt_q != '0) && bus.qcom_rdy_i;
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        tmr_inc  = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 10'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_ISSUE;
                    op_d    = mem_q[rd_ptr_q].op;
                    dt_d    = mem_q[rd_ptr_q].dt;
                end
            end
            ST_ISSUE: begin
                state_d = ST_ACK;
                tmr_d   = '0;
            end
            ST_ACK: begin
                if (!bus.qcom_rdy_i) begin
                    state_d = ST_DONE;
                    tmr_d   = '0;
                end else if (tmr_inc >= ACK_LIM) begin
                    err_set[0] = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            ST_DONE: begin
                if (bus.qcom_rdy_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_inc >= DONE_LIM) begin
                    err_set[1] = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_d   = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
        // A set in the same cycle as a clear takes priority.
        err_d  = (err_q & ~{2{bus.err_clr_i}}) | err_set;

        rsp_vld_d  = bus.qcom_vld_i;
        rsp_dt1_d  = bus.qcom_vld_i ? bus.qcom_dt1_i : rsp_dt1_q;
        rsp_dt2_d  = bus.qcom_vld_i ? bus.qcom_dt2_i : rsp_dt2_q;
        rsp_flag_d = bus.qcom_flag_i;
    end

    // NOTE: FIFO storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge c_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op_i, bus.cmd_dt_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge c_clk_i or posedge c_rst_i) begin
        if (c_rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            op_q       <= '0;
            dt_q       <= '0;
            err_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_dt1_q  <= '0;
            rsp_dt2_q  <= '0;
            rsp_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            op_q       <= op_d;
            dt_q       <= dt_d;
            err_q      <= err_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dt1_q  <= rsp_dt1_d;
            rsp_dt2_q  <= rsp_dt2_d;
            rsp_flag_q <= rsp_flag_d;
        end
    end

    assign bus.cmd_rdy_o  = cmd_rdy;
    assign bus.pend_o     = cnt_q;
    assign bus.qcom_en_o  = en_q;
    assign bus.qcom_op_o  = op_q;
    assign bus.qcom_dt1_o = dt_q;
    assign bus.busy_o     = busy_q;
    assign bus.err_o      = err_q;
    assign bus.rsp_vld_o  = rsp_vld_q;
    assign bus.rsp_dt1_o  = rsp_dt1_q;
    assign bus.rsp_dt2_o  = rsp_dt2_q;
    assign bus.rsp_flag_o = rsp_flag_q;
endmodule
